// File: rtl/match_pkg.sv
// rtl/match_pkg.sv - shared state, winner and digit definitions for match_ctrl
package match_pkg;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_RUN    = 3'd1,
      S_HOLD   = 3'd2,
      S_PAUSED = 3'd3,
      S_OT     = 3'd4,
      S_OVER   = 3'd5
   } state_t;

   localparam logic [1:0] WIN_NONE = 2'b00;
   localparam logic [1:0] WIN_A    = 2'b01;
   localparam logic [1:0] WIN_B    = 2'b10;
   localparam logic [1:0] WIN_DRAW = 2'b11;

   localparam int MIN_W   = 4;
   localparam int SEC10_W = 3;
   localparam int SEC1_W  = 4;
   localparam int SCORE_W = 4;

   typedef struct packed {
      logic [MIN_W-1:0]   min;
      logic [SEC10_W-1:0] sec10;
      logic [SEC1_W-1:0]  sec1;
   } digits_t;

   function automatic digits_t secs_to_digits(input int unsigned secs);
      digits_t d;
      d.min   = MIN_W'(secs / 60);
      d.sec10 = SEC10_W'((secs % 60) / 10);
      d.sec1  = SEC1_W'(secs % 10);
      return d;
   endfunction

   // One-second BCD decrement: sec1 borrows from sec10, sec10 (0..5) borrows from min.
   function automatic digits_t digits_dec(input digits_t d);
      digits_t n;
      n = d;
      if (d.sec1 != '0) begin
         n.sec1 = d.sec1 - SEC1_W'(1);
      end else begin
         n.sec1 = SEC1_W'(9);
         if (d.sec10 != '0) begin
            n.sec10 = d.sec10 - SEC10_W'(1);
         end else begin
            n.sec10 = SEC10_W'(5);
            n.min   = d.min - MIN_W'(1);
         end
      end
      return n;
   endfunction

endpackage

// File: rtl/match_ctrl_if.sv
// rtl/match_ctrl_if.sv - button/sensor inputs and display/solenoid outputs of match_ctrl
interface match_ctrl_if;
   import match_pkg::*;

   logic                 start;
   logic                 pause;
   logic                 goal_a;
   logic                 goal_b;
   logic [MIN_W-1:0]     min;
   logic [SEC10_W-1:0]   sec10;
   logic [SEC1_W-1:0]    sec1;
   logic [SCORE_W-1:0]   score_a;
   logic [SCORE_W-1:0]   score_b;
   logic [2:0]           state;
   logic                 puck_en;
   logic                 game_over;
   logic [1:0]           winner;

   modport master (
      output start, pause, goal_a, goal_b,
      input  min, sec10, sec1, score_a, score_b, state, puck_en, game_over, winner
   );

   modport slave (
      input  start, pause, goal_a, goal_b,
      output min, sec10, sec1, score_a, score_b, state, puck_en, game_over, winner
   );

endinterface

// File: rtl/match_ctrl_tick_gen.sv
// rtl/match_ctrl_tick_gen.sv - 1 Hz prescaler with synchronous clear and run gate
module tick_gen #(
   parameter int CLK_HZ = 50_000_000
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic run,
   output logic tick
);

   localparam int            CW   = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
   localparam logic [CW-1:0] LAST = CW'(CLK_HZ - 1);

   logic [CW-1:0] r_cnt;

   // Tick must not depend on clear: the FSM derives clear from tick-driven expiry.
   assign tick = run && (r_cnt == LAST);

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         r_cnt <= '0;
      end else if (run) begin
         r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + CW'(1);
      end
   end

endmodule

// File: rtl/match_ctrl.sv
// rtl/match_ctrl.sv - air-hockey match FSM, BCD countdown and scoring
// MATCH_OVERTIME_EN: tie at 0:00 enters sudden-death OT instead of ending as a draw.
module match_ctrl
   import match_pkg::*;
#(
   parameter int CLK_HZ    = 50_000_000,
   parameter int MATCH_S   = 120,
   parameter int HOLD_S    = 3,
   parameter int WIN_SCORE = 7
) (
   input logic         clk,
   input logic         reset,
   match_ctrl_if.slave bus
);

   localparam digits_t               START_DIGITS = secs_to_digits(MATCH_S);
   localparam digits_t               ONE_SEC      = secs_to_digits(1);
   localparam int                    HW           = (HOLD_S > 1) ? $clog2(HOLD_S) : 1;
   localparam logic [HW-1:0]         HOLD_LAST    = HW'(HOLD_S - 1);
   localparam logic [SCORE_W-1:0]    WIN_VAL      = SCORE_W'(WIN_SCORE);

   state_t               r_state;
   state_t               r_resume;
   digits_t              r_digits;
   logic [SCORE_W-1:0]   r_score_a;
   logic [SCORE_W-1:0]   r_score_b;
   logic                 r_puck_en;
   logic                 r_game_over;
   logic [1:0]           r_winner;
   logic [HW-1:0]        r_hold_cnt;

   logic                 w_tick;
   logic                 w_clear;
   logic                 w_run;
   logic                 w_live;
   logic                 w_goal_a;
   logic                 w_goal_b;
   logic                 w_goal;
   logic                 w_win;
   logic                 w_tie;
   logic                 w_expire;
   logic [SCORE_W-1:0]   w_score_a;
   logic [SCORE_W-1:0]   w_score_b;
   logic [1:0]           w_goal_winner;
   logic [1:0]           w_lead_winner;
   digits_t              w_digits_dn;

   tick_gen #(.CLK_HZ(CLK_HZ)) u_tick_gen (
      .clk   (clk),
      .reset (reset),
      .clear (w_clear),
      .run   (w_run),
      .tick  (w_tick)
   );

   // Scores after this cycle's goal; expiry and win checks look at these, so a
   // goal on the final tick is counted before the result is decided.
   always_comb begin
      w_live        = (r_state == S_RUN) || (r_state == S_OT);
      w_goal_a      = w_live && bus.goal_a && !bus.goal_b;
      w_goal_b      = w_live && bus.goal_b && !bus.goal_a;
      w_goal        = w_goal_a || w_goal_b;
      w_score_a     = r_score_a + {{(SCORE_W-1){1'b0}}, w_goal_a};
      w_score_b     = r_score_b + {{(SCORE_W-1){1'b0}}, w_goal_b};
      w_win         = (w_goal_a && (w_score_a == WIN_VAL)) || (w_goal_b && (w_score_b == WIN_VAL));
      w_tie         = (w_score_a == w_score_b);
      w_goal_winner = w_goal_a ? WIN_A : WIN_B;
      w_lead_winner = (w_score_a > w_score_b) ? WIN_A : WIN_B;
      w_expire      = (r_state == S_RUN) && w_tick && (r_digits == ONE_SEC);
      w_digits_dn   = digits_dec(r_digits);
      w_run         = (r_state == S_RUN) || (r_state == S_HOLD);
      w_clear       = (((r_state == S_IDLE) || (r_state == S_OVER)) && bus.start)
                   || ((r_state == S_RUN) && w_goal && !w_win && !w_expire);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_resume    <= S_RUN;
         r_digits    <= START_DIGITS;
         r_score_a   <= '0;
         r_score_b   <= '0;
         r_puck_en   <= 1'b0;
         r_game_over <= 1'b0;
         r_winner    <= WIN_NONE;
         r_hold_cnt  <= '0;
      end else begin
         case (r_state)
            S_IDLE, S_OVER: begin
               if (bus.start) begin
                  r_state     <= S_RUN;
                  r_digits    <= START_DIGITS;
                  r_score_a   <= '0;
                  r_score_b   <= '0;
                  r_winner    <= WIN_NONE;
                  r_puck_en   <= 1'b1;
                  r_game_over <= 1'b0;
               end
            end

            S_RUN: begin
               if (w_tick) begin
                  r_digits <= w_digits_dn;
               end
               r_score_a <= w_score_a;
               r_score_b <= w_score_b;
               if (w_win) begin
                  r_state     <= S_OVER;
                  r_puck_en   <= 1'b0;
                  r_game_over <= 1'b1;
                  r_winner    <= w_goal_winner;
               end else if (w_expire) begin
                  if (w_tie) begin
`ifdef MATCH_OVERTIME_EN
                     r_state     <= S_OT;
`else
                     r_state     <= S_OVER;
                     r_puck_en   <= 1'b0;
                     r_game_over <= 1'b1;
                     r_winner    <= WIN_DRAW;
`endif
                  end else begin
                     r_state     <= S_OVER;
                     r_puck_en   <= 1'b0;
                     r_game_over <= 1'b1;
                     r_winner    <= w_lead_winner;
                  end
               end else if (w_goal) begin
                  r_state    <= S_HOLD;
                  r_puck_en  <= 1'b0;
                  r_hold_cnt <= '0;
               end else if (bus.pause) begin
                  r_state   <= S_PAUSED;
                  r_resume  <= S_RUN;
                  r_puck_en <= 1'b0;
               end
            end

            S_HOLD: begin
               if (w_tick) begin
                  if (r_hold_cnt == HOLD_LAST) begin
                     r_state    <= S_RUN;
                     r_puck_en  <= 1'b1;
                     r_hold_cnt <= '0;
                  end else begin
                     r_hold_cnt <= r_hold_cnt + HW'(1);
                  end
               end
            end

            S_PAUSED: begin
               if (bus.pause) begin
                  r_state   <= r_resume;
                  r_puck_en <= 1'b1;
               end
            end

            S_OT: begin
               r_score_a <= w_score_a;
               r_score_b <= w_score_b;
               if (w_goal) begin
                  r_state     <= S_OVER;
                  r_puck_en   <= 1'b0;
                  r_game_over <= 1'b1;
                  r_winner    <= w_goal_winner;
               end else if (bus.pause) begin
                  r_state   <= S_PAUSED;
                  r_resume  <= S_OT;
                  r_puck_en <= 1'b0;
               end
            end

            default: begin
               r_state   <= S_IDLE;
               r_puck_en <= 1'b0;
            end
         endcase
      end
   end

   assign bus.min       = r_digits.min;
   assign bus.sec10     = r_digits.sec10;
   assign bus.sec1      = r_digits.sec1;
   assign bus.score_a   = r_score_a;
   assign bus.score_b   = r_score_b;
   assign bus.state     = r_state;
   assign bus.puck_en   = r_puck_en;
   assign bus.game_over = r_game_over;
   assign bus.winner    = r_winner;

endmodule

// File: tb/tb_match_ctrl.sv
// tb/tb_match_ctrl.sv - scoreboard bench for match_ctrl with two parameter sets
module tb_match_ctrl;
   import match_pkg::*;

   logic clk = 1'b0;
   logic reset;

   always #5 clk = ~clk;

   match_ctrl_if ifa ();
   match_ctrl_if ifb ();

   // A: short match, low win score; B: borrow across a minute, default win score.
   match_ctrl #(.CLK_HZ(4), .MATCH_S(3), .HOLD_S(3), .WIN_SCORE(2)) u_dut_a (
      .clk   (clk),
      .reset (reset),
      .bus   (ifa)
   );

   match_ctrl #(.CLK_HZ(4), .MATCH_S(61), .HOLD_S(3), .WIN_SCORE(7)) u_dut_b (
      .clk   (clk),
      .reset (reset),
      .bus   (ifb)
   );

   logic [25:0] snap_a;
   logic [25:0] snap_b;

   assign snap_a = {ifa.state, ifa.min, ifa.sec10, ifa.sec1, ifa.score_a, ifa.score_b,
                    ifa.puck_en, ifa.game_over, ifa.winner};
   assign snap_b = {ifb.state, ifb.min, ifb.sec10, ifb.sec1, ifb.score_a, ifb.score_b,
                    ifb.puck_en, ifb.game_over, ifb.winner};

   typedef struct {
      bit          sel;
      string       tag;
      logic [25:0] snap;
   } exp_t;

   exp_t sb_q[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   function automatic string fmt(input logic [25:0] s);
      return $sformatf("state=%0d %0d:%0d%0d score=%0d-%0d puck_en=%0b game_over=%0b winner=%b",
                       s[25:23], s[22:19], s[18:16], s[15:12], s[11:8], s[7:4], s[3], s[2], s[1:0]);
   endfunction

   // puck_en and game_over follow from the expected state by definition.
   task automatic push(input bit sel, input string tag, input state_t st,
                       input int mn, input int s10, input int s1,
                       input int sa, input int sb, input logic [1:0] win);
      exp_t e;
      logic pk;
      logic go;
      pk     = (st == S_RUN) || (st == S_OT);
      go     = (st == S_OVER);
      e.sel  = sel;
      e.tag  = tag;
      e.snap = {st, 4'(mn), 3'(s10), 4'(s1), 4'(sa), 4'(sb), pk, go, win};
      sb_q.push_back(e);
   endtask

   task automatic check();
      exp_t        e;
      logic [25:0] act;
      while (sb_q.size() > 0) begin
         e   = sb_q.pop_front();
         act = e.sel ? snap_b : snap_a;
         n_tests++;
         assert (act === e.snap) else begin
            n_fail++;
            $error("FAIL %s observed %s expected %s", e.tag, fmt(act), fmt(e.snap));
         end
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b1;
      ifa.start = 0; ifa.pause = 0; ifa.goal_a = 0; ifa.goal_b = 0;
      ifb.start = 0; ifb.pause = 0; ifb.goal_a = 0; ifb.goal_b = 0;
      cyc(2);
      reset = 1'b0;
      push(0, "a_reset", S_IDLE, 0, 0, 3, 0, 0, WIN_NONE);
      push(1, "b_reset", S_IDLE, 1, 0, 1, 0, 0, WIN_NONE);
      check();

      // Goal in IDLE and pause in IDLE are ignored
      push(0, "a_idle_goal", S_IDLE, 0, 0, 3, 0, 0, WIN_NONE);
      push(1, "b_idle_pause", S_IDLE, 1, 0, 1, 0, 0, WIN_NONE);
      ifa.goal_a = 1; ifb.pause = 1; cyc(1); ifa.goal_a = 0; ifb.pause = 0;
      check();

      // A: regulation ending with a lead
      push(0, "a_start", S_RUN, 0, 0, 3, 0, 0, WIN_NONE);
      ifa.start = 1; cyc(1); ifa.start = 0; check();
      push(0, "a_pre_tick", S_RUN, 0, 0, 3, 0, 0, WIN_NONE);
      cyc(3); check();
      push(0, "a_tick1", S_RUN, 0, 0, 2, 0, 0, WIN_NONE);
      cyc(1); check();
      push(0, "a_goal_hold", S_HOLD, 0, 0, 2, 1, 0, WIN_NONE);
      ifa.goal_a = 1; cyc(1); ifa.goal_a = 0; check();
      push(0, "a_hold_11", S_HOLD, 0, 0, 2, 1, 0, WIN_NONE);
      cyc(11); check();
      push(0, "a_hold_exit", S_RUN, 0, 0, 2, 1, 0, WIN_NONE);
      cyc(1); check();
      push(0, "a_post_hold", S_RUN, 0, 0, 2, 1, 0, WIN_NONE);
      cyc(3); check();
      push(0, "a_tick2", S_RUN, 0, 0, 1, 1, 0, WIN_NONE);
      cyc(1); check();
      push(0, "a_pre_expire", S_RUN, 0, 0, 1, 1, 0, WIN_NONE);
      cyc(3); check();
      push(0, "a_expire_lead", S_OVER, 0, 0, 0, 1, 0, WIN_A);
      cyc(1); check();

      // A: win score reached on second goal
      push(0, "a_restart", S_RUN, 0, 0, 3, 0, 0, WIN_NONE);
      ifa.start = 1; cyc(1); ifa.start = 0; check();
      push(0, "a_goal_b1", S_HOLD, 0, 0, 3, 0, 1, WIN_NONE);
      ifa.goal_b = 1; cyc(1); ifa.goal_b = 0; check();
      push(0, "a_hold_done", S_RUN, 0, 0, 3, 0, 1, WIN_NONE);
      cyc(12); check();
      push(0, "a_win_score", S_OVER, 0, 0, 3, 0, 2, WIN_B);
      ifa.goal_b = 1; cyc(1); ifa.goal_b = 0; check();
      push(0, "a_over_frozen", S_OVER, 0, 0, 3, 0, 2, WIN_B);
      ifa.pause = 1; cyc(1); ifa.pause = 0; cyc(7); check();

      // A: tie at expiry
      push(0, "a_tie_start", S_RUN, 0, 0, 3, 0, 0, WIN_NONE);
      ifa.start = 1; cyc(1); ifa.start = 0; check();
      push(0, "a_tie_pre", S_RUN, 0, 0, 1, 0, 0, WIN_NONE);
      cyc(11); check();
`ifdef MATCH_OVERTIME_EN
      push(0, "a_tie_ot", S_OT, 0, 0, 0, 0, 0, WIN_NONE);
      cyc(1); check();
      push(0, "a_ot_pause", S_PAUSED, 0, 0, 0, 0, 0, WIN_NONE);
      ifa.pause = 1; cyc(1); ifa.pause = 0; check();
      push(0, "a_ot_resume", S_OT, 0, 0, 0, 0, 0, WIN_NONE);
      ifa.pause = 1; cyc(1); ifa.pause = 0; check();
      push(0, "a_sudden_death", S_OVER, 0, 0, 0, 1, 0, WIN_A);
      ifa.goal_a = 1; cyc(1); ifa.goal_a = 0; check();
`else
      push(0, "a_tie_draw", S_OVER, 0, 0, 0, 0, 0, WIN_DRAW);
      cyc(1); check();
      push(0, "a_draw_goal_ignored", S_OVER, 0, 0, 0, 0, 0, WIN_DRAW);
      ifa.goal_a = 1; cyc(1); ifa.goal_a = 0; check();
`endif

      // B: BCD borrow, pause, dual goal, goal on the final tick
      push(1, "b_start", S_RUN, 1, 0, 1, 0, 0, WIN_NONE);
      ifb.start = 1; cyc(1); ifb.start = 0; check();
      push(1, "b_start_ignored", S_RUN, 1, 0, 1, 0, 0, WIN_NONE);
      ifb.start = 1; cyc(1); ifb.start = 0; check();
      push(1, "b_1_00", S_RUN, 1, 0, 0, 0, 0, WIN_NONE);
      cyc(6); check();
      push(1, "b_bcd_borrow", S_RUN, 0, 5, 9, 0, 0, WIN_NONE);
      cyc(1); check();
      push(1, "b_pause", S_PAUSED, 0, 5, 9, 0, 0, WIN_NONE);
      ifb.pause = 1; cyc(1); ifb.pause = 0; check();
      push(1, "b_paused_goal", S_PAUSED, 0, 5, 9, 0, 0, WIN_NONE);
      ifb.goal_a = 1; cyc(1); ifb.goal_a = 0; check();
      push(1, "b_paused_hold", S_PAUSED, 0, 5, 9, 0, 0, WIN_NONE);
      cyc(19); check();
      push(1, "b_resume", S_RUN, 0, 5, 9, 0, 0, WIN_NONE);
      ifb.pause = 1; cyc(1); ifb.pause = 0; check();
      push(1, "b_resume_pre", S_RUN, 0, 5, 9, 0, 0, WIN_NONE);
      cyc(2); check();
      push(1, "b_resume_tick", S_RUN, 0, 5, 8, 0, 0, WIN_NONE);
      cyc(1); check();
      push(1, "b_dual_goal", S_RUN, 0, 5, 8, 0, 0, WIN_NONE);
      ifb.goal_a = 1; ifb.goal_b = 1; cyc(1); ifb.goal_a = 0; ifb.goal_b = 0; check();
      push(1, "b_goal_a", S_HOLD, 0, 5, 8, 1, 0, WIN_NONE);
      ifb.goal_a = 1; ifb.pause = 1; cyc(1); ifb.goal_a = 0; ifb.pause = 0; check();
      push(1, "b_hold1_done", S_RUN, 0, 5, 8, 1, 0, WIN_NONE);
      cyc(12); check();
      push(1, "b_goal_b", S_HOLD, 0, 5, 8, 1, 1, WIN_NONE);
      ifb.goal_b = 1; cyc(1); ifb.goal_b = 0; check();
      push(1, "b_hold2_done", S_RUN, 0, 5, 8, 1, 1, WIN_NONE);
      cyc(12); check();
      push(1, "b_last_second", S_RUN, 0, 0, 1, 1, 1, WIN_NONE);
      cyc(231); check();
      push(1, "b_goal_final_tick", S_OVER, 0, 0, 0, 2, 1, WIN_A);
      ifb.goal_a = 1; cyc(1); ifb.goal_a = 0; check();

      // Reset while B is in HOLD
      push(1, "b_rst_start", S_RUN, 1, 0, 1, 0, 0, WIN_NONE);
      ifb.start = 1; cyc(1); ifb.start = 0; check();
      push(1, "b_rst_hold", S_HOLD, 1, 0, 1, 0, 1, WIN_NONE);
      ifb.goal_b = 1; cyc(1); ifb.goal_b = 0; check();
      cyc(3);
      push(0, "a_mid_reset", S_IDLE, 0, 0, 3, 0, 0, WIN_NONE);
      push(1, "b_mid_reset", S_IDLE, 1, 0, 1, 0, 0, WIN_NONE);
      reset = 1'b1; cyc(1); reset = 1'b0; check();
      push(1, "b_after_reset", S_IDLE, 1, 0, 1, 0, 0, WIN_NONE);
      cyc(4); check();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
